// File: rtl/morse_char_decoder_pkg.sv
// rtl/morse_char_decoder_pkg.sv - shared widths, ASCII codes and S1 stage record for the Morse char decoder
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 6
`endif
`ifndef MORSE_CHAR_W
`define MORSE_CHAR_W 8
`endif
`ifndef ASCII_SPACE
`define ASCII_SPACE 8'h20
`endif
`ifndef ASCII_ERR
`define ASCII_ERR 8'h23
`endif
`ifndef ASCII_UNK
`define ASCII_UNK 8'h2A
`endif

package morse_char_decoder_pkg;
  localparam int LEN_W  = `MORSE_LEN_W;
  localparam int MAX_LEN = `MAX_MORSE_LEN;
  localparam int CHAR_W = `MORSE_CHAR_W;
  localparam int KEY_W  = LEN_W + MAX_LEN;

  localparam logic [CHAR_W-1:0] CODE_SPACE = `ASCII_SPACE;
  localparam logic [CHAR_W-1:0] CODE_ERR   = `ASCII_ERR;
  localparam logic [CHAR_W-1:0] CODE_UNK   = `ASCII_UNK;

  typedef struct packed {
    logic               vld;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] pat;
    logic               err;
    logic               wend;
  } s1_t;

  // Table key: element count followed by the pattern, first element in the MSB.
  function automatic logic [KEY_W-1:0] key(input int l, input int p);
    return {LEN_W'(l), MAX_LEN'(p)};
  endfunction
endpackage

// File: rtl/morse_char_fifo.sv
// rtl/morse_char_fifo.sv - first-word fall-through FIFO; RAM array is unreset, pointers and level reset on aclr
module morse_char_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/morse_char_decoder.sv
// rtl/morse_char_decoder.sv - two-stage Morse-to-ASCII decode into a FIFO; MORSE_DEC_PUNCT_EN adds punctuation
module morse_char_decoder
  import morse_char_decoder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DEBUG = 0
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     ce,
  input  logic                     in_stb,
  input  logic [LEN_W-1:0]         in_len,
  input  logic [MAX_LEN-1:0]       in_dits_dahs,
  input  logic                     in_error,
  input  logic                     in_word_end,
  output logic [CHAR_W-1:0]        out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     ovf_clr
);
  s1_t               s1;
  logic              s2_vld;
  logic [CHAR_W-1:0] s2_code;
  logic [CHAR_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drop;

  function automatic logic [CHAR_W-1:0] lookup(input logic [LEN_W-1:0] len,
                                               input logic [MAX_LEN-1:0] pat);
    logic [MAX_LEN-1:0] mask;
    logic [CHAR_W-1:0]  code;
    mask = ~({MAX_LEN{1'b1}} << len);
    code = CODE_UNK;
    case ({len, pat & mask})
      key(2, 'b01):     code = 8'h41;
      key(4, 'b1000):   code = 8'h42;
      key(4, 'b1010):   code = 8'h43;
      key(3, 'b100):    code = 8'h44;
      key(1, 'b0):      code = 8'h45;
      key(4, 'b0010):   code = 8'h46;
      key(3, 'b110):    code = 8'h47;
      key(4, 'b0000):   code = 8'h48;
      key(2, 'b00):     code = 8'h49;
      key(4, 'b0111):   code = 8'h4A;
      key(3, 'b101):    code = 8'h4B;
      key(4, 'b0100):   code = 8'h4C;
      key(2, 'b11):     code = 8'h4D;
      key(2, 'b10):     code = 8'h4E;
      key(3, 'b111):    code = 8'h4F;
      key(4, 'b0110):   code = 8'h50;
      key(4, 'b1101):   code = 8'h51;
      key(3, 'b010):    code = 8'h52;
      key(3, 'b000):    code = 8'h53;
      key(1, 'b1):      code = 8'h54;
      key(3, 'b001):    code = 8'h55;
      key(4, 'b0001):   code = 8'h56;
      key(3, 'b011):    code = 8'h57;
      key(4, 'b1001):   code = 8'h58;
      key(4, 'b1011):   code = 8'h59;
      key(4, 'b1100):   code = 8'h5A;
      key(5, 'b11111):  code = 8'h30;
      key(5, 'b01111):  code = 8'h31;
      key(5, 'b00111):  code = 8'h32;
      key(5, 'b00011):  code = 8'h33;
      key(5, 'b00001):  code = 8'h34;
      key(5, 'b00000):  code = 8'h35;
      key(5, 'b10000):  code = 8'h36;
      key(5, 'b11000):  code = 8'h37;
      key(5, 'b11100):  code = 8'h38;
      key(5, 'b11110):  code = 8'h39;
`ifdef MORSE_DEC_PUNCT_EN
      key(6, 'b010101): code = 8'h2E;
      key(6, 'b110011): code = 8'h2C;
      key(6, 'b001100): code = 8'h3F;
      key(5, 'b10010):  code = 8'h2F;
      key(5, 'b10001):  code = 8'h3D;
      key(6, 'b100001): code = 8'h2D;
      key(5, 'b10110):  code = 8'h28;
      key(6, 'b101101): code = 8'h29;
`endif
      default:          code = CODE_UNK;
    endcase
    return code;
  endfunction

  function automatic logic [CHAR_W-1:0] decode(input s1_t s);
    if (s.wend)                                         return CODE_SPACE;
    else if (s.err)                                     return CODE_ERR;
    else if (s.len == '0 || s.len > LEN_W'(MAX_LEN))    return CODE_UNK;
    else                                                return lookup(s.len, s.pat);
  endfunction

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      s1      <= '0;
      s2_vld  <= 1'b0;
      s2_code <= '0;
    end else if (ce) begin
      s1.vld <= in_stb;
      if (in_stb) begin
        s1.len  <= in_len;
        s1.pat  <= in_dits_dahs;
        s1.err  <= in_error;
        s1.wend <= in_word_end;
      end
      s2_vld  <= s1.vld;
      s2_code <= decode(s1);
    end
  end

  assign push = ce & s2_vld;
  assign pop  = out_valid & out_ready;
  assign drop = push & fifo_full & ~pop;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  morse_char_fifo #(.W(CHAR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .aclr  (aclr),
    .push  (push),
    .din   (s2_code),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign out_valid = ~fifo_empty;
  // Unreset RAM must not leak onto the port while empty.
  assign out_char  = out_valid ? fifo_dout : '0;

  if (DEBUG != 0) begin : g_debug_trace
  end
endmodule
